regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised two-read/one-write register file with write-through forwarding and a per-register busy scoreboard. It replaces the fixed 8x8 register file in the datapath. The decode stage reads operands on busX/busY and marks destination registers busy at issue. The writeback stage writes results and clears the busy bits. Register 0 is hard-wired to zero.

## Interface
- DATA_W, 8: register width in bits.
- ADDR_W, 3: index width; depth is 2**ADDR_W registers.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- WEN  input  1  writeback enable, active high.
- RW  input  ADDR_W  writeback register index.
- busW  input  DATA_W  writeback data.
- MEN  input  1  issue mark enable: set busy for RM.
- RM  input  ADDR_W  index of register being marked busy.
- RX, RY  input  ADDR_W  read indices.
- busX, busY  output  DATA_W  read data, combinational.
- busyX, busyY  output  1  busy flag for RX/RY, combinational.
- pend_cnt  output  ADDR_W+1  registered count of busy registers.

## Operation
- Storage:
  - 2**ADDR_W registers of DATA_W bits.
  - Register 0 reads as 0 always. Writes and marks to index 0 are ignored.
- Write: on the rising Clk edge with WEN=1 and RW!=0, register[RW] <= busW and busy[RW] <= 0.
- Mark: on the rising Clk edge with MEN=1 and RM!=0, busy[RM] <= 1.
- Same-index write and mark in one cycle (RW==RM, both enables high): data is written and busy ends at 1. The mark wins because it is a new producer.
- Read forwarding (busX; busY identical with RY):
  - If WEN=1, RW!=0 and RW==RX: busX = busW.
  - Else: busX = register[RX].
  - RX=0 gives busX = 0.
- Busy flag (busyX; busyY identical with RY):
  - busyX = busy[RX] & ~(WEN & RW==RX & RX!=0).
  - The flag is 0 for RX=0.
  - A same-cycle mark of RX does not raise busyX until the next cycle.
- pend_cnt:
  - Always equals the population count of the busy vector as it stands after the edge.
  - Update per cycle: +1 for an effective mark of a not-busy register; -1 for an effective write of a busy register that is not re-marked in the same cycle; otherwise unchanged.
  - Re-marking an already-busy register does not change the count.
  - Maximum value is 2**ADDR_W-1; it cannot overflow.
- Reset (Rst_n=0, asynchronous, any time, including mid-write):
  - All registers clear to 0, all busy bits clear to 0, pend_cnt = 0.
  - busX/busY/busyX/busyY therefore read 0 while reset is held.
  - Inputs are ignored until the first rising edge after Rst_n deasserts.

## Timing
- Write latency is 1 edge: plain reads see new data after the edge. Forwarded reads see busW in the same cycle.
- Mark latency is 1 edge to busyX/busyY.
- Reads are purely combinational from RX/RY, register state, WEN/RW/busW.
- No handshake; all enables are single-cycle qualifiers sampled at the rising edge.
- pend_cnt is registered and changes only on the edge or on reset assertion.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - a function computing depth from ADDR_W.
- Sub-module regfile_scoreboard owns the busy vector and pend_cnt.
  - Inputs: Clk, Rst_n, WEN, RW, MEN, RM, RX, RY.
  - Outputs: busyX, busyY, pend_cnt.
- The top level instantiates regfile_scoreboard and owns data storage and forwarding muxes.

## Test plan
All scenarios use DATA_W=8, ADDR_W=3.
- Reset: after Rst_n pulse, RX=0..7 -> busX=0x00, busyX=0, pend_cnt=0. Assert Rst_n mid-run after writing r3=0x5A -> busX(RX=3)=0x00 immediately.
- Write/read/zero:
  - WEN=1, RW=3, busW=0xA5; next cycle RX=3 -> busX=0xA5.
  - WEN=1, RW=0, busW=0xFF -> busX(RX=0)=0x00 forever.
- Forwarding: RX=RY=5, WEN=1, RW=5, busW=0x3C in the same cycle -> busX=busY=0x3C before the edge, with r5 previously 0x00.
- Scoreboard:
  - MEN=1, RM=2 -> next cycle busyX(RX=2)=1, pend_cnt=1.
  - WEN=1, RW=2 -> busyX=0 in the same cycle; after the edge busy[2]=0, pend_cnt=0.
- Simultaneous:
  - MEN=1, RM=4 and WEN=1, RW=4, busW=0x11 in one cycle -> after the edge busX(4)=0x11, busyX=1, pend_cnt=1.
  - Re-mark r4 -> pend_cnt stays 1.
- Fill: mark r1..r7 over 7 cycles -> pend_cnt=7. MEN with RM=0 -> pend_cnt stays 7.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the forwarding register file and its busy scoreboard.
// Default geometry matches the datapath's original 8x8 register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   function automatic int depth_of(input int addrW);
      return 1 << addrW;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits set at issue and cleared at writeback, plus a registered
// count of outstanding producers that always matches the popcount of the busy vector.
import regfile_pkg::*;

module regfile_scoreboard #(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              WEN,
   input  logic [ADDR_W-1:0] RW,
   input  logic              MEN,
   input  logic [ADDR_W-1:0] RM,
   input  logic [ADDR_W-1:0] RX,
   input  logic [ADDR_W-1:0] RY,
   output logic              busyX,
   output logic              busyY,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DEPTH-1:0] r_busy;
   logic [ADDR_W:0]  r_cnt;
   logic [DEPTH-1:0] w_busyNext;
   logic             w_markEff;
   logic             w_writeEff;
   logic             w_inc;
   logic             w_dec;

   // Mark is applied after the write so a same-index pair leaves the register busy.
   always_comb begin
      w_markEff  = MEN && (RM != '0);
      w_writeEff = WEN && (RW != '0);
      w_inc      = w_markEff && !r_busy[RM];
      w_dec      = w_writeEff && r_busy[RW] && !(w_markEff && (RM == RW));
      w_busyNext = r_busy;
      if (w_writeEff) begin
         w_busyNext[RW] = 1'b0;
      end
      if (w_markEff) begin
         w_busyNext[RM] = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busyNext;
         r_cnt  <= r_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
      end
   end

   // A writeback in flight to the read index retires the hazard in the same cycle.
   always_comb begin
      busyX = r_busy[RX] && !(WEN && (RW == RX) && (RX != '0));
      busyY = r_busy[RY] && !(WEN && (RW == RY) && (RY != '0));
   end

   assign pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through forwarding; register 0 reads zero.
// Busy tracking for issued destinations lives in regfile_scoreboard.
import regfile_pkg::*;

module regfile_sb #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              WEN,
   input  logic [ADDR_W-1:0] RW,
   input  logic [DATA_W-1:0] busW,
   input  logic              MEN,
   input  logic [ADDR_W-1:0] RM,
   input  logic [ADDR_W-1:0] RX,
   input  logic [ADDR_W-1:0] RY,
   output logic [DATA_W-1:0] busX,
   output logic [DATA_W-1:0] busY,
   output logic              busyX,
   output logic              busyY,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_fwdX;
   logic              w_fwdY;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (WEN && (RW != '0)) begin
         r_regs[RW] <= busW;
      end
   end

   // Forwarding is gated by reset so the read ports stay at zero while reset is held.
   always_comb begin
      w_fwdX = Rst_n && WEN && (RW != '0) && (RW == RX);
      w_fwdY = Rst_n && WEN && (RW != '0) && (RW == RY);
      busX   = (RX == '0) ? '0 : (w_fwdX ? busW : r_regs[RX]);
      busY   = (RY == '0) ? '0 : (w_fwdY ? busW : r_regs[RY]);
   end

   regfile_scoreboard #(
      .ADDR_W(ADDR_W)
   ) u_scoreboard (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .WEN     (WEN),
      .RW      (RW),
      .MEN     (MEN),
      .RM      (RM),
      .RX      (RX),
      .RY      (RY),
      .busyX   (busyX),
      .busyY   (busyY),
      .pend_cnt(pend_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations,
// a negedge monitor drains the queue and compares against the DUT outputs.
module tb_regfile_sb;

   logic       Clk;
   logic       Rst_n;
   logic       WEN;
   logic [2:0] RW;
   logic [7:0] busW;
   logic       MEN;
   logic [2:0] RM;
   logic [2:0] RX;
   logic [2:0] RY;
   logic [7:0] busX;
   logic [7:0] busY;
   logic       busyX;
   logic       busyY;
   logic [3:0] pend_cnt;

   localparam int SEL_BUSX  = 0;
   localparam int SEL_BUSY  = 1;
   localparam int SEL_BSYX  = 2;
   localparam int SEL_BSYY  = 3;
   localparam int SEL_PEND  = 4;

   typedef struct {
      string name;
      int    sel;
      int    expv;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   regfile_sb #(
      .DATA_W(8),
      .ADDR_W(3)
   ) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .WEN     (WEN),
      .RW      (RW),
      .busW    (busW),
      .MEN     (MEN),
      .RM      (RM),
      .RX      (RX),
      .RY      (RY),
      .busX    (busX),
      .busY    (busY),
      .busyX   (busyX),
      .busyY   (busyY),
      .pend_cnt(pend_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: drains every pending expectation while inputs are stable.
   always @(negedge Clk) begin
      while (expQ.size() > 0) begin
         exp_t e;
         int   act;
         e = expQ.pop_front();
         case (e.sel)
            SEL_BUSX: act = int'(busX);
            SEL_BUSY: act = int'(busY);
            SEL_BSYX: act = int'(busyX);
            SEL_BSYY: act = int'(busyY);
            default:  act = int'(pend_cnt);
         endcase
         checks++;
         if (act != e.expv) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", e.name, act, e.expv);
         end
      end
   end

   task automatic applyStimulus(input logic wen, input logic [2:0] rw, input logic [7:0] bw,
                                input logic men, input logic [2:0] rm,
                                input logic [2:0] rx, input logic [2:0] ry);
      @(posedge Clk);
      #1;
      WEN  = wen;
      RW   = rw;
      busW = bw;
      MEN  = men;
      RM   = rm;
      RX   = rx;
      RY   = ry;
   endtask

   task automatic checkOutput(input string name, input int sel, input int expv);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.expv = expv;
      expQ.push_back(e);
   endtask

   initial begin
      Rst_n = 1'b0;
      WEN = 1'b0; RW = '0; busW = '0; MEN = 1'b0; RM = '0; RX = '0; RY = '0;
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;

      // Reset state across every index
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 8'h00, 0, 0, 3'(i), 3'(i));
         checkOutput($sformatf("rst_busX_r%0d", i), SEL_BUSX, 0);
         checkOutput($sformatf("rst_busyY_r%0d", i), SEL_BSYY, 0);
         checkOutput($sformatf("rst_pend_r%0d", i), SEL_PEND, 0);
      end

      // Plain write then read
      applyStimulus(1, 3, 8'hA5, 0, 0, 0, 0);
      checkOutput("wr_r0_read", SEL_BUSX, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 3, 1);
      checkOutput("rd_r3", SEL_BUSX, 8'hA5);
      checkOutput("rd_r1", SEL_BUSY, 0);

      // Writes to register 0 are dropped, even forwarded
      applyStimulus(1, 0, 8'hFF, 0, 0, 0, 0);
      checkOutput("wr0_fwd_busX", SEL_BUSX, 0);
      checkOutput("wr0_fwd_busY", SEL_BUSY, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 0, 3);
      checkOutput("wr0_after", SEL_BUSX, 0);
      checkOutput("r3_kept", SEL_BUSY, 8'hA5);

      // Write-through forwarding on both ports
      applyStimulus(1, 5, 8'h3C, 0, 0, 5, 5);
      checkOutput("fwd_busX", SEL_BUSX, 8'h3C);
      checkOutput("fwd_busY", SEL_BUSY, 8'h3C);
      applyStimulus(0, 0, 8'h00, 0, 0, 5, 3);
      checkOutput("fwd_stored", SEL_BUSX, 8'h3C);
      checkOutput("fwd_other", SEL_BUSY, 8'hA5);

      // Mark then writeback clears busy
      applyStimulus(0, 0, 8'h00, 1, 2, 2, 2);
      checkOutput("mark_same_cycle", SEL_BSYX, 0);
      checkOutput("mark_pend_before", SEL_PEND, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 2, 2);
      checkOutput("mark_busyX", SEL_BSYX, 1);
      checkOutput("mark_busyY", SEL_BSYY, 1);
      checkOutput("mark_pend", SEL_PEND, 1);
      applyStimulus(1, 2, 8'h77, 0, 0, 2, 3);
      checkOutput("wb_mask_busyX", SEL_BSYX, 0);
      checkOutput("wb_pend_before", SEL_PEND, 1);
      applyStimulus(0, 0, 8'h00, 0, 0, 2, 2);
      checkOutput("wb_busy_clear", SEL_BSYX, 0);
      checkOutput("wb_pend_after", SEL_PEND, 0);
      checkOutput("wb_data", SEL_BUSX, 8'h77);

      // Same-index write and mark: mark wins
      applyStimulus(1, 4, 8'h11, 1, 4, 4, 4);
      checkOutput("sim_fwd", SEL_BUSX, 8'h11);
      checkOutput("sim_busy_now", SEL_BSYX, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 4, 4);
      checkOutput("sim_data", SEL_BUSX, 8'h11);
      checkOutput("sim_busy", SEL_BSYX, 1);
      checkOutput("sim_pend", SEL_PEND, 1);
      applyStimulus(0, 0, 8'h00, 1, 4, 4, 4);
      applyStimulus(0, 0, 8'h00, 0, 0, 4, 4);
      checkOutput("remark_pend", SEL_PEND, 1);
      checkOutput("remark_busyY", SEL_BSYY, 1);

      // Fill every register, r4 already busy
      for (int i = 1; i < 8; i++) begin
         applyStimulus(0, 0, 8'h00, 1, 3'(i), 0, 0);
      end
      applyStimulus(0, 0, 8'h00, 0, 0, 7, 1);
      checkOutput("fill_pend", SEL_PEND, 7);
      checkOutput("fill_busyX", SEL_BSYX, 1);
      checkOutput("fill_busyY", SEL_BSYY, 1);
      applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
      checkOutput("mark0_pend", SEL_PEND, 7);
      checkOutput("mark0_busyX", SEL_BSYX, 0);

      // Writeback of a busy register alongside a mark of a busy one: net -1
      applyStimulus(1, 6, 8'h66, 1, 3, 6, 6);
      applyStimulus(0, 0, 8'h00, 0, 0, 6, 3);
      checkOutput("mixed_pend", SEL_PEND, 6);
      checkOutput("mixed_busyX", SEL_BSYX, 0);
      checkOutput("mixed_busyY", SEL_BSYY, 1);

      // Asynchronous reset in the middle of a run, with a write in flight
      applyStimulus(1, 3, 8'h5A, 0, 0, 0, 0);
      applyStimulus(0, 0, 8'h00, 0, 0, 3, 5);
      checkOutput("pre_rst_r3", SEL_BUSX, 8'h5A);
      @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      WEN = 1'b1; RW = 6; busW = 8'h99; RX = 3; RY = 6;
      checkOutput("rst_r3", SEL_BUSX, 0);
      checkOutput("rst_fwd_blocked", SEL_BUSY, 0);
      checkOutput("rst_busyY", SEL_BSYY, 0);
      checkOutput("rst_pend", SEL_PEND, 0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      WEN = 1'b0; RW = 0; busW = 8'h00; RX = 6; RY = 5;
      checkOutput("post_rst_r6", SEL_BUSX, 0);
      checkOutput("post_rst_r5", SEL_BUSY, 0);
      checkOutput("post_rst_pend", SEL_PEND, 0);

      @(posedge Clk);
      @(posedge Clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drain: actual=%0d required=0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
